// File: rtl/p2s_out_mc.sv
// Multi-channel parallel-to-serial driver for chained shift registers (SCLK/LATCH), all lanes in lockstep.
// Outputs registered; frame = 2*CLK_DIV*DATA_WIDTH + CLK_DIV busy cycles; triggers during a frame collapse into one pending start.
module p2s_out_mc #(
    parameter int DATA_WIDTH = 25,
    parameter int CHANNELS   = 4,
    parameter int CLK_DIV    = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                           CCLK,
    input  logic                           RST_N,
    input  logic                           iTRIG,
    input  logic [CHANNELS*DATA_WIDTH-1:0] iDATA,
    output logic [CHANNELS-1:0]            oSERIAL,
    output logic                           oSCLK,
    output logic                           oLATCH,
    output logic                           oBUSY,
    output logic                           oDONE
);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SHIFT_LO = 2'd1;
    localparam logic [1:0] S_SHIFT_HI = 2'd2;
    localparam logic [1:0] S_LATCH    = 2'd3;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("p2s_out_mc: CLK_DIV must be >= 1");
    end
    if (DATA_WIDTH < 2) begin : g_bad_data_width
        $error("p2s_out_mc: DATA_WIDTH must be >= 2");
    end

    logic [1:0]                   state_q, state_d;
    logic [DVW-1:0]               div_q, div_d;
    logic [BCW-1:0]               bit_q, bit_d;
    logic [CHANNELS*DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                         pend_q, pend_d;
    logic [CHANNELS-1:0]          serial_q, serial_d;
    logic                         sclk_q, sclk_d;
    logic                         latch_q, latch_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         phase_end;
    logic [BCW-1:0]               sel;

    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        case (state_q)
            S_IDLE: begin
                if (iTRIG || pend_q) begin
                    shadow_d = iDATA;
                    bit_d    = '0;
                    div_d    = '0;
                    pend_d   = 1'b0;
                    state_d  = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: begin
                if (phase_end) begin
                    div_d   = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (phase_end) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_LATCH;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                if (phase_end) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
        // Any number of requests during a frame collapse into one queued start
        if (state_q != S_IDLE && iTRIG) begin
            pend_d = 1'b1;
        end
    end

    // Outputs are derived from next-state values so they register in step with the FSM
    assign sel     = (MSB_FIRST != 0) ? (BIT_LAST - bit_d) : bit_d;
    assign sclk_d  = (state_d == S_SHIFT_HI);
    assign latch_d = (state_d == S_LATCH);
    assign busy_d  = (state_d != S_IDLE);
    assign done_d  = (state_q == S_LATCH) && (state_d == S_IDLE);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] slice;
        assign slice       = shadow_d[k*DATA_WIDTH +: DATA_WIDTH];
        assign serial_d[k] = busy_d && slice[sel];
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            serial_q <= '0;
            sclk_q   <= 1'b0;
            latch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            serial_q <= serial_d;
            sclk_q   <= sclk_d;
            latch_q  <= latch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oSERIAL = serial_q;
    assign oSCLK   = sclk_q;
    assign oLATCH  = latch_q;
    assign oBUSY   = busy_q;
    assign oDONE   = done_q;

endmodule

// File: doc/p2s_out_mc.md
P2S_OUT_MC -- requirements
Module: p2s_out_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 25: bits per channel per frame (>=2).
REQ-002 Parameter CHANNELS, default 4: parallel serial lanes sharing one clock/latch (>=1).
REQ-003 Parameter CLK_DIV, default 4: CCLK cycles per oSCLK half-period (>=1); values <1 SHALL be a parameter error at elaboration.
REQ-004 Parameter MSB_FIRST, default 1: 1 = bit DATA_WIDTH-1 shifted first, 0 = bit 0 first.
REQ-005 Port CCLK  in  1  system clock; all logic on rising edge.
REQ-006 Port RST_N  in  1  reset, asynchronous, active-low; clock CCLK.
REQ-007 Port iTRIG  in  1  frame start request, level-sampled each CCLK.
REQ-008 Port iDATA  in  CHANNELS*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port oSERIAL  out  CHANNELS  serial data, bit k = channel k.
REQ-010 Port oSCLK  out  1  shift clock to downstream shift registers.
REQ-011 Port oLATCH  out  1  storage-register latch strobe.
REQ-012 Port oBUSY  out  1  frame in progress.
REQ-013 Port oDONE  out  1  one-cycle frame-complete pulse.

Function
REQ-014 All outputs SHALL be registered (no combinational path from inputs).
REQ-015 FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, LATCH; encoding free.
REQ-016 IDLE: on rising CCLK with iTRIG=1 (or pending flag set), capture iDATA into a shadow register, clear bit counter, go SHIFT_LO.
REQ-017 iDATA SHALL be sampled only at the IDLE->SHIFT_LO edge; later iDATA changes SHALL NOT affect the frame.
REQ-018 SHIFT_LO: oSCLK=0, oSERIAL[k] = current bit of channel k; hold CLK_DIV cycles, then go SHIFT_HI.
REQ-019 SHIFT_HI: oSCLK=1, oSERIAL unchanged (data stable across rising oSCLK); hold CLK_DIV cycles.
REQ-020 Leaving SHIFT_HI: if bit counter = DATA_WIDTH-1 go LATCH, else increment counter, advance to next bit, go SHIFT_LO.
REQ-021 LATCH: oSCLK=0, oLATCH=1 for CLK_DIV cycles, oSERIAL holds last bit; then go IDLE.
REQ-022 oDONE SHALL be 1 for exactly the first cycle after LATCH ends (the first IDLE cycle), 0 otherwise.
REQ-023 oBUSY SHALL be 1 in SHIFT_LO, SHIFT_HI, LATCH; frame length = 2*CLK_DIV*DATA_WIDTH + CLK_DIV cycles of oBUSY=1.
REQ-024 In IDLE: oSCLK=0, oLATCH=0, oSERIAL=0.
REQ-025 iTRIG=1 while oBUSY=1 SHALL set a single pending flag; multiple such requests collapse into one.
REQ-026 Pending flag set at frame end: next frame starts on the first IDLE cycle (oDONE and start edge coincide); oBUSY returns to 1 after exactly one IDLE cycle; pending flag clears at start.
REQ-027 Bit counter width SHALL be $clog2(DATA_WIDTH); divide counter width $clog2(CLK_DIV) min 1; no wrap beyond DATA_WIDTH-1.
REQ-028 All channels SHALL shift in lockstep; channel k output depends only on channel k slice.

Reset
REQ-029 RST_N=0 SHALL immediately force state IDLE, counters 0, shadow 0, pending 0, and oSERIAL, oSCLK, oLATCH, oBUSY, oDONE all 0.
REQ-030 Reset mid-frame SHALL abort without oLATCH or oDONE; after RST_N release, no frame starts until iTRIG=1 is sampled.

Verification (DATA_WIDTH=4, CHANNELS=2, CLK_DIV=1 unless stated)
REQ-031 Single frame: iDATA=8'hA5, MSB_FIRST=1, 1-cycle iTRIG -> ch0 bits 0,1,0,1, ch1 bits 1,0,1,0 on 4 oSCLK rising edges; oBUSY high 9 cycles; oLATCH 1 cycle; oDONE 1 cycle.
REQ-032 MSB_FIRST=0, iDATA=8'h1E -> ch0 sequence 0,1,1,1; ch1 sequence 1,0,0,0.
REQ-033 CLK_DIV=3: oSCLK high/low phases each 3 cycles; oBUSY high 27 cycles; oLATCH high 3 cycles.
REQ-034 iTRIG pulsed 3 times during a frame, iDATA changed mid-frame -> current frame unchanged; exactly one extra frame with iDATA value at its start edge; one IDLE cycle between frames.
REQ-035 RST_N asserted during SHIFT_HI of bit 2 -> all outputs 0 same cycle; no oDONE; subsequent iTRIG yields a full correct frame.
REQ-036 iTRIG held high continuously -> back-to-back frames, oDONE once per frame, one IDLE cycle between frames.
